// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with RISC-V load/store lane handling
//
// Owns the data RAM and serves one load or store per cycle over a valid/ready
// request channel, returning a single-cycle response pulse.
//
// Optional feature macro: DMEM_MISALIGN_SPLIT_EN
//   defined   - misaligned accesses run as two word accesses (SPLIT state)
//   undefined - misaligned accesses complete in one cycle with rsp_err=1
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   request handshake (ready only in IDLE)
//   req_write               1 = store, 0 = load
//   req_addr                byte address (word index [DM_ADDRESS-1:2], lane [1:0])
//   req_funct3              RISC-V funct3 (size / signedness)
//   req_wdata               right-aligned store data
//   rsp_valid               one-cycle response pulse per accepted request
//   rsp_rdata               load result (0 for stores and errors)
//   rsp_err                 illegal funct3 or unsupported misaligned access

module dmem_responder #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  localparam int IDX_W = DM_ADDRESS - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {IDLE, SPLIT} state_e;

  // Byte/half/word extraction from a little-endian two-word window.
  function automatic logic [31:0] load_extract(input logic [63:0] win,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [63:0] s;
    s = win >> {off, 3'b000};
    case (f3)
      3'b000:  load_extract = {{24{s[7]}}, s[7:0]};
      3'b001:  load_extract = {{16{s[15]}}, s[15:0]};
      3'b010:  load_extract = s[31:0];
      3'b100:  load_extract = {24'h0, s[7:0]};
      3'b101:  load_extract = {16'h0, s[15:0]};
      default: load_extract = 32'h0;
    endcase
  endfunction

  // Store data replicated so that any lane shift lands the right bytes.
  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] wd);
    case (f3)
      3'b000:  store_data = {4{wd[7:0]}};
      3'b001:  store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [3:0] base_be(input logic [2:0] f3);
    case (f3)
      3'b000:  base_be = 4'b0001;
      3'b001:  base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
  endfunction

  logic [31:0] mem_q [DEPTH];

  state_e      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // Split holding registers: second word index and what to do there.
  logic [IDX_W-1:0] split_idx_q, split_idx_d;
  logic [1:0]       split_off_q, split_off_d;
  logic [2:0]       split_f3_q, split_f3_d;
  logic             split_write_q, split_write_d;
  logic [31:0]      split_lo_q, split_lo_d;
  logic [3:0]       split_be_hi_q, split_be_hi_d;
  logic [31:0]      split_wdata_hi_q, split_wdata_hi_d;

  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_off;
  logic             legal, misaligned;
  logic [7:0]       be8;
  logic [63:0]      wd64;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_word;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;

  assign req_idx   = req_addr[DM_ADDRESS-1:2];
  assign req_off   = req_addr[1:0];
  assign req_ready = (state_q == IDLE);

  always_comb begin
    if (req_write) legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                           (req_funct3 == 3'b010);
    else           legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                           (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                           (req_funct3 == 3'b101);
  end

  // funct3[1:0] encodes size for every legal load/store.
  assign misaligned = ((req_funct3[1:0] == 2'b01) && (req_off == 2'b11)) ||
                      ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));

  // Enables and data span two words; the upper half only matters on a split.
  assign be8  = {4'b0000, base_be(req_funct3)} << req_off;
  assign wd64 = {32'h0, store_data(req_funct3, req_wdata[31:0])} << {req_off, 3'b000};

  assign rd_idx  = (state_q == SPLIT) ? split_idx_q : req_idx;
  assign rd_word = mem_q[rd_idx];

  always_comb begin
    state_d          = state_q;
    rsp_valid_d      = 1'b0;
    rsp_rdata_d      = 32'h0;
    rsp_err_d        = 1'b0;
    split_idx_d      = split_idx_q;
    split_off_d      = split_off_q;
    split_f3_d       = split_f3_q;
    split_write_d    = split_write_q;
    split_lo_d       = split_lo_q;
    split_be_hi_d    = split_be_hi_q;
    split_wdata_hi_d = split_wdata_hi_q;
    mem_we           = 1'b0;
    mem_idx          = req_idx;
    mem_be           = be8[3:0];
    mem_wdata        = wd64[31:0];

    if (state_q == IDLE) begin
      if (req_valid) begin
        if (!legal || (misaligned && !SplitEn)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          mem_we = req_write;
          if (misaligned) begin
            state_d          = SPLIT;
            split_idx_d      = req_idx + 1'b1;  // wraps modulo depth
            split_off_d      = req_off;
            split_f3_d       = req_funct3;
            split_write_d    = req_write;
            split_lo_d       = rd_word;
            split_be_hi_d    = be8[7:4];
            split_wdata_hi_d = wd64[63:32];
          end else begin
            rsp_valid_d = 1'b1;
            if (!req_write) rsp_rdata_d = load_extract({32'h0, rd_word}, req_off, req_funct3);
          end
        end
      end
    end else begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      mem_we      = split_write_q;
      mem_idx     = split_idx_q;
      mem_be      = split_be_hi_q;
      mem_wdata   = split_wdata_hi_q;
      if (!split_write_q) rsp_rdata_d = load_extract({rd_word, split_lo_q}, split_off_q, split_f3_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= 32'h0;
      rsp_err_q        <= 1'b0;
      split_idx_q      <= '0;
      split_off_q      <= 2'b00;
      split_f3_q       <= 3'b000;
      split_write_q    <= 1'b0;
      split_lo_q       <= 32'h0;
      split_be_hi_q    <= 4'h0;
      split_wdata_hi_q <= 32'h0;
    end else begin
      state_q          <= state_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_err_q        <= rsp_err_d;
      split_idx_q      <= split_idx_d;
      split_off_q      <= split_off_d;
      split_f3_q       <= split_f3_d;
      split_write_q    <= split_write_d;
      split_lo_q       <= split_lo_d;
      split_be_hi_q    <= split_be_hi_d;
      split_wdata_hi_q <= split_wdata_hi_d;
    end
  end

  // Storage is not reset; per-byte enables preserve unselected lanes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [8:0]  req_addr = 9'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv(input logic w, input logic [8:0] a, input logic [2:0] f3, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = wd;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  // Single-cycle request; response checked in the following cycle.
  task automatic op1(input string tag, input logic w, input logic [8:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    drv(w, a, f3, wd);
    tick();
    idle();
    chk({tag, ".valid"}, {31'h0, rsp_valid}, 32'h1);
    chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_err});
  endtask

  // Split access: ready low and no response at T+1, response at T+2.
  task automatic op2(input string tag, input logic w, input logic [8:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, input logic [31:0] exp_rd);
    drv(w, a, f3, wd);
    tick();
    idle();
    chk({tag, ".ready_t1"}, {31'h0, req_ready}, 32'h0);
    chk({tag, ".valid_t1"}, {31'h0, rsp_valid}, 32'h0);
    tick();
    chk({tag, ".valid_t2"}, {31'h0, rsp_valid}, 32'h1);
    chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".err"}, {31'h0, rsp_err}, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst.ready", {31'h0, req_ready}, 32'h1);
    chk("rst.valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst.rdata", rsp_rdata, 32'h0);
    chk("rst.err", {31'h0, rsp_err}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Back-to-back SW then LW, one response per cycle
    drv(1'b1, 9'h010, 3'b010, 32'h8899AABB);
    tick();
    chk("sw.valid", {31'h0, rsp_valid}, 32'h1);
    chk("sw.rdata", rsp_rdata, 32'h0);
    chk("sw.ready", {31'h0, req_ready}, 32'h1);
    drv(1'b0, 9'h010, 3'b010, 32'h0);
    tick();
    idle();
    chk("lw_b2b.valid", {31'h0, rsp_valid}, 32'h1);
    chk("lw_b2b.rdata", rsp_rdata, 32'h8899AABB);
    chk("lw_b2b.err", {31'h0, rsp_err}, 32'h0);
    tick();
    chk("idle.valid", {31'h0, rsp_valid}, 32'h0);

    // Sign / zero extension and lane selection
    op1("lb013",  1'b0, 9'h013, 3'b000, 32'h0, 32'hFFFFFF88, 1'b0);
    op1("lbu013", 1'b0, 9'h013, 3'b100, 32'h0, 32'h00000088, 1'b0);
    op1("lh010",  1'b0, 9'h010, 3'b001, 32'h0, 32'hFFFFAABB, 1'b0);
    op1("lhu012", 1'b0, 9'h012, 3'b101, 32'h0, 32'h00008899, 1'b0);

    // Partial stores preserve other lanes
    op1("sb011",  1'b1, 9'h011, 3'b000, 32'h000000CC, 32'h0, 1'b0);
    op1("lw_sb",  1'b0, 9'h010, 3'b010, 32'h0, 32'h8899CCBB, 1'b0);
    op1("sh012",  1'b1, 9'h012, 3'b001, 32'h00001234, 32'h0, 1'b0);
    op1("lw_sh",  1'b0, 9'h010, 3'b010, 32'h0, 32'h1234CCBB, 1'b0);

    // Misaligned word load spanning 0x010/0x014
    op1("sw014",  1'b1, 9'h014, 3'b010, 32'h00000000, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_SPLIT_EN
    op2("lw011", 1'b0, 9'h011, 3'b010, 32'h0, 32'h001234CC);
    tick();
    chk("lw011.pulse_once", {31'h0, rsp_valid}, 32'h0);
    chk("lw011.ready_back", {31'h0, req_ready}, 32'h1);
`else
    op1("lw011", 1'b0, 9'h011, 3'b010, 32'h0, 32'h0, 1'b1);
`endif

    // Illegal funct3: error, no memory update
    op1("ld_f3_011", 1'b0, 9'h010, 3'b011, 32'h0, 32'h0, 1'b1);
    op1("st_f3_100", 1'b1, 9'h010, 3'b100, 32'hFFFFFFFF, 32'h0, 1'b1);
    op1("lw_noupd",  1'b0, 9'h010, 3'b010, 32'h0, 32'h1234CCBB, 1'b0);

    // Top word and wrap to word 0
    op1("sw1fc", 1'b1, 9'h1FC, 3'b010, 32'h11223344, 32'h0, 1'b0);
    op1("sw000", 1'b1, 9'h000, 3'b010, 32'h55667788, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_SPLIT_EN
    op2("sw1fe", 1'b1, 9'h1FE, 3'b010, 32'hAABBCCDD, 32'h0);
    op1("lw1fc_wrap", 1'b0, 9'h1FC, 3'b010, 32'h0, 32'hCCDD3344, 1'b0);
    op1("lw000_wrap", 1'b0, 9'h000, 3'b010, 32'h0, 32'h5566AABB, 1'b0);
`else
    op1("sw1fe", 1'b1, 9'h1FE, 3'b010, 32'hAABBCCDD, 32'h0, 1'b1);
    op1("lw1fc_nowr", 1'b0, 9'h1FC, 3'b010, 32'h0, 32'h11223344, 1'b0);
    op1("lw000_nowr", 1'b0, 9'h000, 3'b010, 32'h0, 32'h55667788, 1'b0);
`endif

    // Reset pulsed during the split of a misaligned store
    op1("sw00c", 1'b1, 9'h00C, 3'b010, 32'h00000000, 32'h0, 1'b0);
    drv(1'b1, 9'h00D, 3'b010, 32'hDEADBEEF);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rstsplit.ready_async", {31'h0, req_ready}, 32'h1);
    chk("rstsplit.valid_async", {31'h0, rsp_valid}, 32'h0);
    tick();
    chk("rstsplit.valid_held", {31'h0, rsp_valid}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rstsplit.valid_after", {31'h0, rsp_valid}, 32'h0);
    chk("rstsplit.ready_after", {31'h0, req_ready}, 32'h1);
`ifdef DMEM_MISALIGN_SPLIT_EN
    op1("lw00c_half", 1'b0, 9'h00C, 3'b010, 32'h0, 32'hADBEEF00, 1'b0);
`else
    op1("lw00c_half", 1'b0, 9'h00C, 3'b010, 32'h0, 32'h00000000, 1'b0);
`endif
    op1("lw010_keep", 1'b0, 9'h010, 3'b010, 32'h0, 32'h1234CCBB, 1'b0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. It owns the data RAM. It accepts one load or store per cycle over a valid/ready request channel and applies RISC-V funct3 semantics: byte lanes, byte enables, and sign or zero extension. It returns a single-cycle response pulse with read data or an error flag. It sits between the load/store stage and the storage array and replaces lane handling inside the CPU datapath.

## Interface
- DM_ADDRESS, 9: byte-address width; storage is 2^(DM_ADDRESS-2) words.
- DATA_W, 32: data width; only 32 is supported.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; a transfer occurs when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  DM_ADDRESS  byte address.
- req_funct3  in  3  instruction bits 14:12.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse, one per accepted request.
- rsp_rdata  out  DATA_W  load result; 0 for stores and errors.
- rsp_err  out  1  request rejected; no memory update.

## Operation
- Address fields: word index = req_addr[DM_ADDRESS-1:2]; lane offset = req_addr[1:0].
- Loads:
  - LB (000) and LH (001) sign-extend.
  - LW (010) returns the whole word.
  - LBU (100) and LHU (101) zero-extend.
  - The byte or half is taken from lane offset×8.
- Stores:
  - SB (000): byte enable 0001 << offset, data replicated across all lanes.
  - SH (001): byte enable 0011 << offset.
  - SW (010): byte enable 1111.
  - Unselected bytes are preserved.
- Illegal funct3 gives rsp_err=1, rsp_rdata=0 and no write:
  - loads: 011, 110, 111;
  - stores: any value other than 000/001/010.
- Misaligned accesses: halfword at offset 3; word at offset ≠ 0. Handling is set under Configuration.
- States:
  - IDLE: req_ready=1.
  - SPLIT: req_ready=0; completes the second word of a split access; always returns to IDLE after one cycle.
- No response backpressure; the requester must sample rsp_* in the pulse cycle.
- Storage contents are not reset and are undefined until written.

## Timing
- Reset values:
  - req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Split holding registers are cleared to 0.
- Aligned or error request accepted at edge T:
  - A store is written at edge T.
  - rsp_valid=1 with data during cycle T+1.
  - Back-to-back transfers give one response per cycle with no bubble.
- Split request accepted at edge T:
  - Word w is read or written at T; the FSM enters SPLIT.
  - Word w+1 is read or written at T+1. The index wraps modulo depth, so the top word's successor is word 0.
  - rsp_valid in cycle T+2.
  - req_ready=0 during cycle T+1, so the next transfer is at T+2 or later.
- A load to the same word as a store accepted the cycle before returns the new data (write-before-read ordering at the edge).
- Reset mid-split:
  - The FSM returns to IDLE and no response is issued.
  - The first half of a split store, already written, remains in memory.
- rsp_valid is never high in two consecutive cycles for a single request.

## Configuration
- DMEM_MISALIGN_SPLIT_EN defined:
  - Misaligned loads and stores are carried out as two word accesses via SPLIT.
  - Load bytes are concatenated in little-endian order, then extended.
  - Store byte enables span both words.
- DMEM_MISALIGN_SPLIT_EN undefined:
  - Misaligned requests complete in one cycle with rsp_err=1, rsp_rdata=0 and no write.
  - The SPLIT state is never entered.

## Test plan
- Reset, then SW addr 0x010 data 0x8899AABB, then LW 0x010 → rsp_rdata 0x8899AABB, rsp_err=0, latency 1 cycle each, back-to-back.
- After that store: LB 0x013 → 0xFFFFFF88; LBU 0x013 → 0x00000088; LH 0x010 → 0xFFFFAABB; LHU 0x012 → 0x00008899.
- SB 0x011 data 0x000000CC, then LW 0x010 → 0x8899CCBB; SH 0x012 data 0x1234, then LW 0x010 → 0x1234CCBB.
- LW 0x011 after the stores above:
  - with macro: rsp at T+2, req_ready low at T+1; 0x014 holds 0 → rsp_rdata 0x001234CC;
  - without macro: rsp_err=1, rsp_rdata=0 at T+1.
- Funct3 011 load and funct3 100 store → rsp_err=1, memory unchanged; SW at top word 0x1FC plus SW 0x1FE (with macro) → lanes 2-3 of 0x1FC and lanes 0-1 of word 0 updated.
- rst_n pulsed low during SPLIT of a misaligned SW 0x00D data 0xDEADBEEF → no rsp_valid, req_ready=1 after release; bytes 0x00D-0x00F hold 0xEF, 0xBE, 0xAD; byte 0x010 unchanged.
